// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time program loader. Accepts a header word plus a
// stream of 32-bit instruction words over valid/ready, and writes each word
// into the byte-wide instruction memory, little-endian. The core is held in
// reset until a load completes.
//
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   start        begin a load (honoured in IDLE, DONE, ERR)
//   in_valid     in_data carries a word
//   in_ready     loader accepts in_data this cycle (state-decoded)
//   in_data      header word ({MAGIC, N}) or instruction word
//   imem_we      byte write strobe
//   imem_addr    byte address of the write
//   imem_wdata   byte being written
//   core_rst     core reset, low only in DONE
//   busy         loading (HDR, WAIT, WR)
//   done         load complete
//   err          header rejected
module imem_boot_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter logic [15:0] MAGIC  = 16'hB007
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned WORD_W    = ADDR_W - 2;
    localparam int unsigned CNT_W     = ADDR_W - 1;
    localparam int unsigned MAX_WORDS = 1 << WORD_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WAIT,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [31:0]         word;
    logic [1:0]          byte_k;
    logic [WORD_W-1:0]   word_idx;
    logic [CNT_W-1:0]    words_left;

    logic                xfer;
    logic [15:0]         hdr_n;
    logic                hdr_bad;
    logic                hdr_zero;

    // Header decode; the count bound keeps the last address at 2^ADDR_W-1.
    assign xfer     = in_valid && in_ready;
    assign hdr_n    = in_data[15:0];
    assign hdr_bad  = (in_data[31:16] != MAGIC) || (32'(hdr_n) > MAX_WORDS);
    assign hdr_zero = (hdr_n == 16'd0);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    if (hdr_bad) begin
                        state_nxt = S_ERR;
                    end else if (hdr_zero) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (xfer) begin
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (byte_k == 2'd3) begin
                    state_nxt = (words_left == CNT_W'(1)) ? S_DONE : S_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: word buffer, byte index and word counters
    always_ff @(posedge clk) begin
        if (rst) begin
            word       <= 32'd0;
            byte_k     <= 2'd0;
            word_idx   <= '0;
            words_left <= '0;
        end else begin
            case (state)
                S_HDR: begin
                    if (xfer && !hdr_bad && !hdr_zero) begin
                        words_left <= CNT_W'(hdr_n);
                        word_idx   <= '0;
                    end
                end
                S_WAIT: begin
                    if (xfer) begin
                        word   <= in_data;
                        byte_k <= 2'd0;
                    end
                end
                S_WR: begin
                    byte_k <= byte_k + 2'd1;
                    if (byte_k == 2'd3) begin
                        word_idx   <= word_idx + WORD_W'(1);
                        words_left <= words_left - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode from registered state and datapath only
    always_comb begin
        in_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = 8'd0;
        core_rst   = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_HDR: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WAIT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            S_WR: begin
                busy       = 1'b1;
                imem_we    = 1'b1;
                // word_idx*4 + k, byte k taken little-endian from the word
                imem_addr  = ADDR_W'({word_idx, byte_k});
                imem_wdata = word[{byte_k, 3'b000} +: 8];
            end
            S_DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: randomized loads checked against a
// byte-image memory model and an expected-write scoreboard.
module tb_imem_boot_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned MEM_SZ = 1 << ADDR_W;
    localparam int unsigned MAXW   = MEM_SZ / 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              err;

    imem_boot_loader #(.ADDR_W(ADDR_W), .MAGIC(16'hB007)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_wr = 0;
    int          last_wr_addr = -1;
    int          last_fin = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  dut_mem [MEM_SZ];
    logic [7:0]  exp_mem [MEM_SZ];
    int          exp_wr_q [$];
    logic [31:0] ld_words [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory capture plus per-cycle invariants
    always @(negedge clk) begin
        if (mon_en) begin
            check("we_while_ready", {31'b0, imem_we & in_ready}, 32'd0);
            check("core_rst_vs_done", {31'b0, core_rst}, {31'b0, ~done});
            if (imem_we === 1'b1) begin
                n_wr++;
                last_wr_addr = int'(imem_addr);
                dut_mem[imem_addr] = imem_wdata;
                check("wr_expected", {31'b0, exp_wr_q.size() != 0}, 32'd1);
                if (exp_wr_q.size() != 0) begin
                    int e;
                    e = exp_wr_q.pop_front();
                    check("wr_addr", 32'(imem_addr), 32'(e >> 8));
                    check("wr_data", 32'(imem_wdata), 32'(e & 255));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_mem(input string tag);
        for (int a = 0; a < int'(MEM_SZ); a++) begin
            if (dut_mem[a] !== exp_mem[a]) check({tag, "_mem"}, 32'(dut_mem[a]), 32'(exp_mem[a]));
            else n_cmp++;
        end
    endtask

    // mode 0: in_valid high; 1: in_valid alternating 1-0-1; 2: random valid and start pulses.
    // abort_word >= 0: pulse rst during the second write cycle of that word.
    task automatic do_load(input logic [31:0] hdr, input int mode, input int abort_word, input string tag);
        int          n;
        bit          bad;
        logic [31:0] items [$];
        int          idx;
        int          c0;
        int          wr0;
        int          guard;
        bit          ph;
        bit          xf;
        bit          aborted;
        int          cnt;

        n   = int'(hdr[15:0]);
        bad = (hdr[31:16] != 16'hB007) || (n > int'(MAXW));
        items.delete();
        items.push_back(hdr);
        if (!bad) begin
            for (int i = 0; i < n; i++) begin
                items.push_back(ld_words[i]);
                for (int b = 0; b < 4; b++)
                    exp_wr_q.push_back(((4 * i + b) << 8) | int'((ld_words[i] >> (8 * b)) & 32'hFF));
            end
        end
        wr0 = n_wr;
        c0  = cyc;

        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = hdr;
        tick();
        start = 1'b0;
        check({tag, "_c1_core_rst"}, {31'b0, core_rst}, 32'd1);
        check({tag, "_c1_busy"}, {31'b0, busy}, 32'd1);

        idx = 0; guard = 0; ph = 1'b1; aborted = 1'b0;
        while (idx < items.size() && !aborted) begin
            bit v;
            case (mode)
                0: v = 1'b1;
                1: begin v = ph; ph = ~ph; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            start    = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            in_valid = v;
            in_data  = v ? items[idx] : $urandom();
            @(negedge clk);
            xf = in_valid && in_ready;
            tick();
            if (xf) idx++;
            if (abort_word >= 0 && xf && idx == abort_word + 2) aborted = 1'b1;
            guard++;
            if (guard > 5000) begin
                check({tag, "_send_timeout"}, 32'(idx), 32'(items.size()));
                break;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;

        if (aborted) begin
            tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check({tag, "_rst_we"}, {31'b0, imem_we}, 32'd0);
            check({tag, "_rst_core_rst"}, {31'b0, core_rst}, 32'd1);
            check({tag, "_rst_busy"}, {31'b0, busy}, 32'd0);
            check({tag, "_rst_done"}, {31'b0, done}, 32'd0);
            check({tag, "_rst_err"}, {31'b0, err}, 32'd0);
            check({tag, "_rst_left"}, 32'(exp_wr_q.size()), 32'(4 * n - (4 * abort_word + 2)));
            exp_wr_q.delete();
            for (int i = 0; i < abort_word; i++)
                for (int b = 0; b < 4; b++) exp_mem[4 * i + b] = 8'((ld_words[i] >> (8 * b)) & 32'hFF);
            exp_mem[4 * abort_word]     = ld_words[abort_word][7:0];
            exp_mem[4 * abort_word + 1] = ld_words[abort_word][15:8];
            cmp_mem(tag);
            return;
        end

        cnt = 0;
        while (!(done === 1'b1 || err === 1'b1) && cnt < 1000) begin
            tick();
            cnt++;
        end
        check({tag, "_finish_in_time"}, {31'b0, cnt < 1000}, 32'd1);
        last_fin = cyc - c0;
        if (mode == 0) check({tag, "_fin_cycle"}, 32'(last_fin), 32'(bad ? 2 : 5 * n + 2));
        check({tag, "_done"}, {31'b0, done}, {31'b0, ~bad});
        check({tag, "_err"}, {31'b0, err}, {31'b0, bad});
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_core_rst"}, {31'b0, core_rst}, {31'b0, bad});
        check({tag, "_n_writes"}, 32'(n_wr - wr0), 32'(bad ? 0 : 4 * n));
        check({tag, "_q_empty"}, 32'(exp_wr_q.size()), 32'd0);
        exp_wr_q.delete();
        if (!bad)
            for (int i = 0; i < n; i++)
                for (int b = 0; b < 4; b++) exp_mem[4 * i + b] = 8'((ld_words[i] >> (8 * b)) & 32'hFF);
        cmp_mem(tag);
    endtask

    task automatic rand_words(input int n);
        ld_words.delete();
        for (int i = 0; i < n; i++) ld_words.push_back($urandom());
    endtask

    initial begin
        logic [31:0] nom [8];
        nom = '{32'h00007033, 32'h00007033, 32'h00208433, 32'h404404b3,
                32'h00317533, 32'h0041e5b3, 32'h00007033, 32'h00007033};
        for (int a = 0; a < int'(MEM_SZ); a++) begin
            dut_mem[a] = 8'd0;
            exp_mem[a] = 8'd0;
        end
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        repeat (3) tick();
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_we", {31'b0, imem_we}, 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", 32'(imem_wdata), 32'd0);
        check("rst_core_rst", {31'b0, core_rst}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Nominal image, in_valid held high
        ld_words.delete();
        for (int i = 0; i < 8; i++) ld_words.push_back(nom[i]);
        do_load(32'hB0070008, 0, -1, "nom");
        check("nom_a8",  32'(dut_mem[8]),  32'h33);
        check("nom_a9",  32'(dut_mem[9]),  32'h84);
        check("nom_a10", 32'(dut_mem[10]), 32'h20);
        check("nom_a11", 32'(dut_mem[11]), 32'h00);
        check("nom_a20", 32'(dut_mem[20]), 32'hb3);
        check("nom_a21", 32'(dut_mem[21]), 32'he5);
        check("nom_a22", 32'(dut_mem[22]), 32'h41);
        check("nom_a23", 32'(dut_mem[23]), 32'h00);

        // Same image under alternating backpressure
        do_load(32'hB0070008, 1, -1, "bp");
        check("bp_later", {31'b0, last_fin > 42}, 32'd1);

        // Header errors and empty program
        ld_words.delete();
        do_load(32'hDEAD0004, 0, -1, "bad_magic");
        do_load(32'hB0070041, 0, -1, "too_long");
        do_load(32'hB0070000, 0, -1, "empty");

        // Full memory
        rand_words(int'(MAXW));
        do_load(32'hB0070040, 0, -1, "full");
        check("full_last_addr", 32'(last_wr_addr), 32'd255);

        // Reset during WR of word 3, then a clean reload
        rand_words(8);
        do_load(32'hB0070008, 0, 3, "abort");
        rand_words(8);
        do_load(32'hB0070008, 2, -1, "after_abort");

        // Reloads from DONE with random backpressure and ignored start pulses
        for (int t = 0; t < 5; t++) begin
            int n;
            n = int'($urandom_range(1, 20));
            rand_words(n);
            do_load({16'hB007, 16'(n)}, int'($urandom_range(0, 2)), -1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader for the single-cycle RISC-V core. It accepts a header word and a stream of 32-bit instruction words over a valid/ready interface, then writes each word into the byte-wide instruction memory in little-endian order (byte 0 at the lowest address). The core is held in reset until the load completes. It sits between the host/debug link and the instruction memory write port, and drives the core's reset.

## Interface
- ADDR_W, 8, instruction-memory byte-address width; capacity 2^ADDR_W bytes = 2^(ADDR_W-2) words
- MAGIC, 16'hB007, required value of header bits [31:16]
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset; synchronous, active-high
- start  input  1  begin a load; sampled only in IDLE, DONE or ERR
- in_valid  input  1  in_data holds a valid word
- in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid && in_ready
- in_data  input  32  header word or instruction word
- imem_we  output  1  byte write strobe to instruction memory
- imem_addr  output  ADDR_W  byte address of the write
- imem_wdata  output  8  byte being written
- core_rst  output  1  reset to the core; 1 in every state except DONE
- busy  output  1  state is HDR, WAIT or WR
- done  output  1  state is DONE
- err  output  1  state is ERR

## Operation
- States: IDLE, HDR, WAIT, WR, DONE, ERR. Outputs decode from registered state and registered datapath; no input-to-output combinational path except none (in_ready depends on state only).
- IDLE: in_ready=0. start=1 -> HDR.
- HDR: in_ready=1. On transfer: N = in_data[15:0]. If in_data[31:16] != MAGIC, or N > 2^(ADDR_W-2) -> ERR. If N == 0 -> DONE. Otherwise latch words_left=N, word_idx=0 -> WAIT.
- WAIT: in_ready=1. On transfer, latch the word, byte index k=0 -> WR.
- WR: in_ready=0. imem_we=1, imem_addr = word_idx*4 + k, imem_wdata = word[8k+7:8k]. k increments each cycle. After k=3: word_idx+1, words_left-1; if words_left reaches 0 -> DONE, else -> WAIT.
- DONE: core_rst=0, done=1. start=1 -> HDR (core_rst reasserts the next cycle).
- ERR: err=1, core_rst=1. start=1 -> HDR. No further memory writes occur.
- start is ignored in HDR, WAIT and WR.
- Address arithmetic is ADDR_W bits wide; the N bound guarantees that no wrap-around occurs.

## Timing
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, busy=0, done=0, err=0, counters=0.
- Reset mid-load: the next cycle is IDLE with core_rst=1 and imem_we=0. Bytes already written remain in memory.
- Each word takes 1 accept cycle plus 4 write cycles, so at least 5 cycles per word.
- With start at cycle 0 and in_valid held high: header accepted at cycle 1, word k accepted at cycle 2+5k, its writes occur in cycles 3+5k..6+5k, and DONE is reached at cycle 5N+2.
- Backpressure: when in_valid=0, HDR and WAIT hold indefinitely and all outputs stay stable. in_data is ignored when no transfer occurs.
- core_rst falls on the same edge that enters DONE.

## Test plan
- Nominal load, N=8, in_valid held high: header 32'hB0070008, then words 00007033, 00007033, 00208433, 404404b3, 00317533, 0041e5b3, 00007033, 00007033. Required: addr 8..11 receive 33,84,20,00; addr 20..23 receive b3,e5,41,00; done=1 and core_rst=0 at cycle 42.
- Backpressure: same load with in_valid toggled 1-0-1 on each word. Required: memory image identical to the nominal case, DONE reached later, and no write strobe during WAIT.
- Header errors: header 32'hDEAD0004 -> ERR, no imem_we ever asserted. Header 32'hB0070041 with ADDR_W=8 (65 > 64) -> ERR. Header 32'hB0070000 -> DONE at cycle 2.
- Boundary: N=64 with ADDR_W=8. Required: last byte written at addr 255 and no wrap to address 0.
- Reset mid-load: assert rst during WR of word 3. Required: IDLE next cycle, imem_we=0, core_rst=1. A subsequent start followed by a full reload completes normally.
- Reload: start in DONE. Required: core_rst=1 on the next cycle, the second image overwrites the first, and start pulses during WR are ignored.
